// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - programmable integer clock divider with load/busy ratio handshake
// Optional lock output enabled by defining CLK_DIV_LOCK_EN.
module clk_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_val,
  output logic             div_busy,
  output logic [WIDTH-1:0] div_cur,
  output logic             clk_out,
  output logic             clk_tick,
  output logic             running
`ifdef CLK_DIV_LOCK_EN
  ,
  output logic             lock
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cur_d;
  logic [WIDTH-1:0] pend_val_q, pend_val_d;
  logic [WIDTH-1:0] load_val;
  logic             pending_q, pending_d;
  logic             clk_out_d, clk_tick_d;
  logic             wrap;

  // Ratios below 2 cannot form a high and a low phase, so they collapse to 2.
  assign load_val = (div_val[WIDTH-1:1] == '0) ? WIDTH'(2) : div_val;
  assign wrap     = (cnt_q == div_cur - WIDTH'(1));
  assign div_busy = pending_q;
  assign running  = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_d      = div_cur;
    pending_d  = pending_q;
    pend_val_d = pend_val_q;
    clk_out_d  = 1'b0;
    clk_tick_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (div_load) cur_d = load_val;
        if (en) begin
          state_d    = RUN;
          clk_out_d  = 1'b1;
          clk_tick_d = 1'b1;
        end
      end
      RUN, STOPPING: begin
        if (div_load && !pending_q) begin
          pending_d  = 1'b1;
          pend_val_d = load_val;
        end
        if (wrap) begin
          // Period boundary: the only point where a pending ratio may take effect.
          cnt_d = '0;
          if (pending_q) begin
            cur_d     = pend_val_q;
            pending_d = 1'b0;
          end
          if (en) begin
            state_d    = RUN;
            clk_out_d  = 1'b1;
            clk_tick_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d     = cnt_q + WIDTH'(1);
          state_d   = en ? RUN : STOPPING;
          clk_out_d = (cnt_d < (div_cur >> 1));
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_cur    <= WIDTH'(DEFAULT_DIV);
      pending_q  <= 1'b0;
      pend_val_q <= '0;
      clk_out    <= 1'b0;
      clk_tick   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_cur    <= cur_d;
      pending_q  <= pending_d;
      pend_val_q <= pend_val_d;
      clk_out    <= clk_out_d;
      clk_tick   <= clk_tick_d;
    end
  end

`ifdef CLK_DIV_LOCK_EN
  logic [1:0] per_q;

  // Counts completed RUN periods since the last ratio change, saturating at 2.
  always_ff @(posedge clk) begin
    if (!rst) begin
      per_q <= 2'd0;
      lock  <= 1'b0;
    end else if (state_d != RUN) begin
      per_q <= 2'd0;
      lock  <= 1'b0;
    end else if (state_q == RUN && wrap) begin
      if (pending_q) begin
        per_q <= 2'd0;
        lock  <= 1'b0;
      end else if (per_q != 2'd2) begin
        per_q <= per_q + 2'd1;
        lock  <= (per_q == 2'd1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - directed self-checking bench for clk_div_prog
module tb_clk_div_prog;

  logic       clk;
  logic       rst;
  logic       en;
  logic       div_load;
  logic [7:0] div_val;
  logic       div_busy;
  logic [7:0] div_cur;
  logic       clk_out;
  logic       clk_tick;
  logic       running;
`ifdef CLK_DIV_LOCK_EN
  logic       lock;
`endif

  int n_tests;
  int n_fail;

  clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_load (div_load),
    .div_val  (div_val),
    .div_busy (div_busy),
    .div_cur  (div_cur),
    .clk_out  (clk_out),
    .clk_tick (clk_tick),
    .running  (running)
`ifdef CLK_DIV_LOCK_EN
    ,
    .lock     (lock)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic co, input logic tk,
                            input logic bz, input int cur, input logic rn);
    check({tag, ".clk_out"}, 32'(clk_out), 32'(co));
    check({tag, ".clk_tick"}, 32'(clk_tick), 32'(tk));
    check({tag, ".div_busy"}, 32'(div_busy), 32'(bz));
    check({tag, ".div_cur"}, 32'(div_cur), cur);
    check({tag, ".running"}, 32'(running), 32'(rn));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b0;
    en       = 1'b0;
    div_load = 1'b0;
    div_val  = 8'd0;
    step();
    step();
    expect_out("reset", 0, 0, 0, 4, 0);
`ifdef CLK_DIV_LOCK_EN
    check("reset.lock", 32'(lock), 0);
`endif
    rst = 1'b1;
    step();
    expect_out("idle", 0, 0, 0, 4, 0);

    // R=4: 1,1,0,0 with a tick on the first cycle after en
    en = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      expect_out($sformatf("r4_%0d", i), (i % 4) < 2, (i % 4) == 0, 0, 4, 1);
    end
    step();
    expect_out("r4_wrap", 1, 1, 0, 4, 1);

    // load 3 mid-period: busy until wrap, then 1,0,0
    div_load = 1'b1; div_val = 8'd3;
    step();
    div_load = 1'b0;
    expect_out("ld3_c1", 1, 0, 1, 4, 1);
    step();
    expect_out("ld3_c2", 0, 0, 1, 4, 1);
    step();
    expect_out("ld3_c3", 0, 0, 1, 4, 1);
    step();
    expect_out("ld3_wrap", 1, 1, 0, 3, 1);
    for (int i = 1; i <= 6; i++) begin
      step();
      c = i % 3;
      expect_out($sformatf("r3_%0d", i), c == 0, c == 0, 0, 3, 1);
    end

    // load 0 maps to 2
    div_load = 1'b1; div_val = 8'd0;
    step();
    div_load = 1'b0;
    expect_out("ld0_c1", 0, 0, 1, 3, 1);
    step();
    expect_out("ld0_c2", 0, 0, 1, 3, 1);
    step();
    expect_out("ld0_wrap", 1, 1, 0, 2, 1);
    for (int i = 1; i <= 4; i++) begin
      step();
      expect_out($sformatf("r2_%0d", i), (i % 2) == 0, (i % 2) == 0, 0, 2, 1);
    end

    // pending 5, then a load of 7 on the wrap cycle is ignored
    div_load = 1'b1; div_val = 8'd5;
    step();
    expect_out("ld5_c1", 0, 0, 1, 2, 1);
    div_val = 8'd7;
    step();
    div_load = 1'b0;
    expect_out("ld5_wrap", 1, 1, 0, 5, 1);
    for (int i = 1; i <= 5; i++) begin
      step();
      c = i % 5;
      expect_out($sformatf("r5_%0d", i), c < 2, c == 0, 0, 5, 1);
    end

    // load 1 maps to 2; a mid-period load of 7 while busy is ignored
    div_load = 1'b1; div_val = 8'd1;
    step();
    expect_out("ld1_c1", 1, 0, 1, 5, 1);
    div_val = 8'd7;
    step();
    div_load = 1'b0;
    expect_out("ld1_c2", 0, 0, 1, 5, 1);
    step();
    expect_out("ld1_c3", 0, 0, 1, 5, 1);
    step();
    expect_out("ld1_c4", 0, 0, 1, 5, 1);
    step();
    expect_out("ld1_wrap", 1, 1, 0, 2, 1);

    // load on the wrap cycle while not pending applies one period later
    step();
    expect_out("ldw_c1", 0, 0, 0, 2, 1);
    div_load = 1'b1; div_val = 8'd6;
    step();
    div_load = 1'b0;
    expect_out("ldw_wrap1", 1, 1, 1, 2, 1);
    step();
    expect_out("ldw_c1b", 0, 0, 1, 2, 1);
    step();
    expect_out("ldw_wrap2", 1, 1, 0, 6, 1);

    // drop en in the high phase with R=6: period completes then IDLE
    step();
    expect_out("stop_c1", 1, 0, 0, 6, 1);
    en = 1'b0;
    step();
    expect_out("stop_c2", 1, 0, 0, 6, 1);
    for (int i = 3; i <= 5; i++) begin
      step();
      expect_out($sformatf("stop_c%0d", i), 0, 0, 0, 6, 1);
    end
    step();
    expect_out("stop_idle", 0, 0, 0, 6, 0);
    step();
    expect_out("stop_idle2", 0, 0, 0, 6, 0);

    // re-raise en before the wrap: continuous output
    en = 1'b1;
    step();
    expect_out("rer_c0", 1, 1, 0, 6, 1);
    step();
    expect_out("rer_c1", 1, 0, 0, 6, 1);
    step();
    expect_out("rer_c2", 1, 0, 0, 6, 1);
    en = 1'b0;
    step();
    expect_out("rer_c3", 0, 0, 0, 6, 1);
    en = 1'b1;
    step();
    expect_out("rer_c4", 0, 0, 0, 6, 1);
    step();
    expect_out("rer_c5", 0, 0, 0, 6, 1);
    step();
    expect_out("rer_wrap", 1, 1, 0, 6, 1);

    en = 1'b0;
    for (int i = 0; i < 6; i++) step();
    expect_out("to_idle", 0, 0, 0, 6, 0);

    // load in IDLE applies immediately without busy
    div_load = 1'b1; div_val = 8'd3;
    step();
    div_load = 1'b0;
    expect_out("ld_idle", 0, 0, 0, 3, 0);

    // load in STOPPING is held and applied at the wrap into IDLE
    en = 1'b1;
    step();
    expect_out("lds_c0", 1, 1, 0, 3, 1);
    en = 1'b0;
    step();
    expect_out("lds_c1", 0, 0, 0, 3, 1);
    div_load = 1'b1; div_val = 8'd5;
    step();
    div_load = 1'b0;
    expect_out("lds_c2", 0, 0, 1, 3, 1);
    step();
    expect_out("lds_idle", 0, 0, 0, 5, 0);

    // reset mid-period with a pending load
    en = 1'b1;
    step();
    expect_out("rst_c0", 1, 1, 0, 5, 1);
    div_load = 1'b1; div_val = 8'd9;
    step();
    div_load = 1'b0;
    expect_out("rst_c1", 1, 0, 1, 5, 1);
    rst = 1'b0;
    step();
    expect_out("rst_mid", 0, 0, 0, 4, 0);
    rst = 1'b1;
    step();
    expect_out("rst_rel", 1, 1, 0, 4, 1);
    for (int i = 0; i < 4; i++) step();
    expect_out("rst_wrap", 1, 1, 0, 4, 1);

`ifdef CLK_DIV_LOCK_EN
    check("lock_p1", 32'(lock), 0);
    for (int i = 0; i < 4; i++) step();
    check("lock_p2", 32'(lock), 1);
    div_load = 1'b1; div_val = 8'd2;
    step();
    div_load = 1'b0;
    check("lock_pend", 32'(lock), 1);
    step();
    step();
    check("lock_c3", 32'(lock), 1);
    step();
    check("lock_clr", 32'(lock), 0);
    check("lock_cur", 32'(div_cur), 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Programmable integer clock divider.
- Sits directly upstream of the 2x clock multiplier stage and produces the base clock that stage doubles.
- Runs from one system clock; generates a registered, glitch-free divided clock `clk_out` plus a one-cycle rising-edge strobe.
- Ratio changes are applied only at period boundaries, under a load/busy handshake.

Parameters:
- WIDTH, 8, width of the divide-ratio value.
- DEFAULT_DIV, 4, ratio loaded at reset (must be >= 2 and < 2^WIDTH).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- en  input  1  run request; level-sensitive.
- div_load  input  1  one-cycle request to load div_val as the new ratio.
- div_val  input  WIDTH  requested ratio R; values 0 and 1 are treated as 2.
- div_busy  output  1  high while a loaded ratio is pending.
- div_cur  output  WIDTH  ratio currently in effect.
- clk_out  output  1  divided clock, registered.
- clk_tick  output  1  one-cycle pulse on the clk cycle where clk_out goes 0->1.
- running  output  1  high in state RUN or STOPPING.

Behaviour:
- Reset (rst=0 at a clk edge) sets:
  - clk_out=0, clk_tick=0, div_busy=0, running=0
  - div_cur=DEFAULT_DIV, pending=0, cnt=0, state=IDLE
- Reset overrides all inputs, including mid-period; the pending load is discarded.
- Period and duty:
  - Period is R clk cycles, driven by cnt running 0..R-1.
  - clk_out=1 while cnt < R/2 (floor division), 0 otherwise.
  - Odd R: high floor(R/2), low ceil(R/2). Example: R=3 gives 1 high / 2 low; R=2 gives 1/1.
- clk_out and clk_tick are registers with no combinational path from inputs.
- States:
  - IDLE: clk_out=0, cnt=0. If en=1 is sampled, go to RUN; the next cycle has cnt=0, clk_out=1, clk_tick=1. First rising edge is 1 cycle after en is sampled.
  - RUN: cnt increments each cycle and wraps R-1 -> 0.
    - At the wrap, if pending, div_cur takes the pending value and div_busy drops the same cycle. The new period starts with cnt=0 using the new R.
    - If en=0 is sampled, go to STOPPING.
  - STOPPING: finish the current period without truncation. At cnt=R-1, go to IDLE (clk_out stays 0).
    - If en returns to 1 before the wrap, return to RUN with no gap and no extra edge.
- Load handshake:
  - div_load=1 while div_busy=0: div_val is latched (0/1 mapped to 2) and div_busy=1 from the next cycle.
  - div_load while div_busy=1 is ignored; the first pending value wins.
  - Load in IDLE is applied immediately: div_cur updates next cycle and div_busy is never asserted.
  - Load in STOPPING is held pending and applied at the wrap into IDLE.
- Simultaneous events:
  - div_load on the wrap cycle while pending: the old pending value applies and the new request is ignored.
  - div_load on the wrap cycle while not pending: the value is latched and applies at the next wrap.
- clk_tick is asserted only when clk_out rises. No pulse on stop, and no pulse in IDLE.

Optional Feature:
- Macro: CLK_DIV_LOCK_EN.
- When defined, adds output `lock` (1 bit, reset 0):
  - Asserts after 2 complete periods in RUN with no ratio change.
  - Clears the cycle a new ratio is applied, on leaving RUN, or on reset.
  - Downstream multiplier stage may gate its output on lock.
- When not defined: no lock port and no lock logic. All other behaviour is identical.

Test Plan:
- Reset then en=1, DEFAULT_DIV=4 -> clk_out 1,1,0,0 repeating; clk_tick every 4 cycles; first tick 1 cycle after en.
- Load div_val=3 during RUN -> div_busy=1 until next wrap; then div_cur=3 and clk_out 1,0,0 repeating; no runt pulse at the switch.
- Load div_val=1 (and separately 0) -> div_cur=2, clk_out toggles every cycle.
- Second div_load (div_val=7) while busy with pending 5 -> ignored; div_cur becomes 5.
- Drop en mid-high-phase with R=6 -> period completes (3 high, 3 low), then IDLE with clk_out=0 and running=0. Re-raise en before the wrap -> continuous output.
- Assert rst=0 mid-period with pending load -> next cycle all outputs at reset values and div_cur=DEFAULT_DIV. With CLK_DIV_LOCK_EN: lock rises after 2 full periods and clears on the ratio-change cycle.
